// File: rtl/mcif_rsp_demux4_if.sv
// Bus bundle for mcif_rsp_demux4: command recording, memory read-data and
// client read-data channels. Optional cli_last exists when MCIF_RSP_LAST_EN
// is defined.
interface mcif_rsp_demux4_if #(
  parameter int DW     = 128,
  parameter int LEN_W  = 4,
  parameter int TRK_AW = 3
);
  logic              cmd_push;
  logic [1:0]        cmd_id;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_full;
  logic [TRK_AW:0]   trk_cnt;
  logic              rd_vld;
  logic [DW-1:0]     rd_data;
  logic              rd_rdy;
  logic [3:0]        cli_vld;
  logic [DW-1:0]     cli_data;
  logic [3:0]        cli_rdy;
  logic              orphan_err;
`ifdef MCIF_RSP_LAST_EN
  logic              cli_last;

  modport master (
    output cmd_push, cmd_id, cmd_len, rd_vld, rd_data, cli_rdy,
    input  cmd_full, trk_cnt, rd_rdy, cli_vld, cli_data, orphan_err, cli_last
  );
  modport slave (
    input  cmd_push, cmd_id, cmd_len, rd_vld, rd_data, cli_rdy,
    output cmd_full, trk_cnt, rd_rdy, cli_vld, cli_data, orphan_err, cli_last
  );
`else
  modport master (
    output cmd_push, cmd_id, cmd_len, rd_vld, rd_data, cli_rdy,
    input  cmd_full, trk_cnt, rd_rdy, cli_vld, cli_data, orphan_err
  );
  modport slave (
    input  cmd_push, cmd_id, cmd_len, rd_vld, rd_data, cli_rdy,
    output cmd_full, trk_cnt, rd_rdy, cli_vld, cli_data, orphan_err
  );
`endif
endinterface

// File: rtl/mcif_rsp_demux4.sv
// mcif_rsp_demux4: routes memory read beats back to the client that issued
// the read. Each issued read records {grant id, beats-1} in an in-order
// tracking FIFO; beats are counted against the head entry, which pops on its
// last beat. Define MCIF_RSP_LAST_EN to add the cli_last end-of-burst flag.
module mcif_rsp_demux4 #(
  parameter int DW        = 128,
  parameter int LEN_W     = 4,
  parameter int TRK_DEPTH = 8,
  parameter int TRK_AW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mcif_rsp_demux4_if.slave    bus
);

  typedef struct packed {
    logic [1:0]       id;
    logic [LEN_W-1:0] len;
  } trk_t;

  localparam logic [TRK_AW:0] DEPTH_V = (TRK_AW+1)'(TRK_DEPTH);

  trk_t              trk_mem [TRK_DEPTH];
  logic [TRK_AW-1:0] wr_ptr, rd_ptr;
  logic [TRK_AW:0]   cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              orphan;

  trk_t              head;
  logic              head_vld, full, push, beat, last, pop, rdy;
  logic [3:0]        lane_vld;

  assign head     = trk_mem[rd_ptr];
  assign head_vld = (cnt != '0);
  // Full is judged on registered occupancy only, so a pop in the same cycle
  // never lets a push through.
  assign full     = (cnt == DEPTH_V);
  assign push     = bus.cmd_push & ~full;
  assign rdy      = head_vld & bus.cli_rdy[head.id];
  assign beat     = bus.rd_vld & rdy;
  assign last     = (beat_cnt == head.len);
  assign pop      = beat & last;

  // One valid lane per client; only the head entry's client sees the beat.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_vld[i] = bus.rd_vld & head_vld & (head.id == 2'(i));
  end

  assign bus.cli_vld    = lane_vld;
  assign bus.cli_data   = bus.rd_data;
  assign bus.rd_rdy     = rdy;
  assign bus.cmd_full   = full;
  assign bus.trk_cnt    = cnt;
  assign bus.orphan_err = orphan;
`ifdef MCIF_RSP_LAST_EN
  assign bus.cli_last   = (lane_vld != 4'b0000) & last;
`endif

  // Tracking storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) trk_mem[wr_ptr] <= '{id: bus.cmd_id, len: bus.cmd_len};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at TRK_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Beat counter within the head burst; restarts on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    beat_cnt <= '0;
    else if (beat) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
  end

  // Sticky flag for a beat presented with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        orphan <= 1'b0;
    else if (bus.rd_vld & ~head_vld)   orphan <= 1'b1;
  end

endmodule

// File: tb/tb_mcif_rsp_demux4.sv
// Bench for mcif_rsp_demux4: directed scenarios plus randomized traffic.
// Stimulus records each issued command in a queue; a negedge monitor holds a
// queue-level model of outstanding bursts and compares every cycle.
module tb_mcif_rsp_demux4;
  localparam int DW = 128, LEN_W = 4, DEPTH = 8, AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcif_rsp_demux4_if #(.DW(DW), .LEN_W(LEN_W), .TRK_AW(AW)) bus();

  mcif_rsp_demux4 #(.DW(DW), .LEN_W(LEN_W), .TRK_DEPTH(DEPTH), .TRK_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] len;
  } cmd_t;

  cmd_t exp_cmd[$];
  int   checks = 0, failures = 0;
  int   mdl_cnt = 0, mdl_beat = 0;
  bit   mdl_orph = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: model state reflects everything up to the last edge.
  initial begin
    cmd_t h;
    logic [3:0] ev;
    bit er, popd, pushok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_trk_cnt", bus.trk_cnt, 0);
        chk("rst_cmd_full", bus.cmd_full, 0);
        chk("rst_rd_rdy", bus.rd_rdy, 0);
        chk("rst_cli_vld", bus.cli_vld, 0);
        chk("rst_orphan", bus.orphan_err, 0);
        exp_cmd.delete();
        mdl_cnt = 0; mdl_beat = 0; mdl_orph = 1'b0;
      end else begin
        chk("trk_cnt", bus.trk_cnt, mdl_cnt);
        chk("cmd_full", bus.cmd_full, (mdl_cnt == DEPTH));
        chk("orphan_err", bus.orphan_err, mdl_orph);
        ev = 4'b0000; er = 1'b0; h = '0;
        if (mdl_cnt > 0) begin
          h  = exp_cmd[0];
          ev = bus.rd_vld ? (4'b0001 << h.id) : 4'b0000;
          er = bus.cli_rdy[h.id];
        end
        chk("cli_vld", bus.cli_vld, ev);
        chk("rd_rdy", bus.rd_rdy, er);
        if (ev != 4'b0000) chk("cli_data", bus.cli_data, bus.rd_data);
`ifdef MCIF_RSP_LAST_EN
        chk("cli_last", bus.cli_last, (ev != 4'b0000) && (mdl_beat == int'(h.len)));
`endif
        popd = 1'b0;
        if (bus.rd_vld && er) begin
          if (mdl_beat == int'(h.len)) begin
            void'(exp_cmd.pop_front());
            mdl_beat = 0;
            popd = 1'b1;
          end else mdl_beat++;
        end
        if (bus.rd_vld && mdl_cnt == 0) mdl_orph = 1'b1;
        pushok = bus.cmd_push && (mdl_cnt < DEPTH);
        mdl_cnt = mdl_cnt + int'(pushok) - int'(popd);
      end
    end
  end

  // Present one cycle of inputs, then advance to just after the next edge.
  task automatic drive(input bit push, input logic [1:0] id, input logic [3:0] len,
                       input bit rv, input logic [3:0] rdy);
    if (push && bus.cmd_full) push = 1'b0;
    bus.cmd_push = push && rst_n;
    bus.cmd_id   = id;
    bus.cmd_len  = len;
    bus.rd_vld   = rv;
    bus.rd_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.cli_rdy  = rdy;
    if (push && rst_n) exp_cmd.push_back('{id: id, len: len});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 4'd0, 1'b0, 4'hF);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_cmd.size() > 0 && n < 300) begin
      drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
      n++;
    end
    checks++;
    if (exp_cmd.size() > 0) begin
      failures++;
      $display("FAIL %s outstanding=%0d required=0", name, exp_cmd.size());
    end
  endtask

  initial begin
    int len0;
    bus.cmd_push = 1'b0; bus.cmd_id = '0; bus.cmd_len = '0;
    bus.rd_vld = 1'b0; bus.rd_data = '0; bus.cli_rdy = 4'hF;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single 4-beat burst to client 2.
    drive(1'b1, 2'd2, 4'd3, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    chk("burst4_trk_cnt", bus.trk_cnt, 0);
    idle(2);

    // Back-to-back single-beat bursts to clients 1,3,0.
    drive(1'b1, 2'd1, 4'd0, 1'b0, 4'hF);
    drive(1'b1, 2'd3, 4'd0, 1'b1, 4'hF);
    drive(1'b1, 2'd0, 4'd0, 1'b1, 4'hF);
    drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    idle(2);
    chk("b2b_orphan", bus.orphan_err, 0);

    // Fill to full, pop one, push+pop together, refill, drain (pointer wrap).
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b0, 4'hF);
    chk("fill_full", bus.cmd_full, 1);
    chk("fill_cnt", bus.trk_cnt, DEPTH);
    len0 = int'(exp_cmd[0].len);
    for (int i = 0; i <= len0; i++) drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    chk("pop_cnt", bus.trk_cnt, DEPTH - 1);
    len0 = int'(exp_cmd[0].len);
    for (int i = 0; i <= len0; i++)
      drive(i == len0, 2'd3, 4'd15, 1'b1, 4'hF);
    chk("pushpop_cnt", bus.trk_cnt, DEPTH - 1);
    drive(1'b1, 2'd1, 4'd2, 1'b0, 4'hF);
    chk("refill_full", bus.cmd_full, 1);
    drain("fill_drain");
    idle(2);

    // Client stall holds the beat at the memory side.
    drive(1'b1, 2'd1, 4'd1, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 4'd0, 1'b1, 4'b1101);
    chk("stall_cnt", bus.trk_cnt, 1);
    drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    chk("stall_done_cnt", bus.trk_cnt, 0);
    idle(1);

    // Orphan beat sets a sticky error.
    drive(1'b0, 2'd0, 4'd0, 1'b1, 4'hF);
    idle(3);
    chk("orphan_sticky", bus.orphan_err, 1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic with a reset in the middle of bursts.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700 || c == 701) rst_n = 1'b0;
      else rst_n = 1'b1;
      drive(($urandom % 3) == 0, 2'($urandom), 4'($urandom),
            (($urandom % 4) != 0) && (exp_cmd.size() > 0 || ($urandom % 60) == 0),
            4'($urandom) | (($urandom % 2) ? 4'hF : 4'h0));
    end
    rst_n = 1'b1;
    drain("rand_drain");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
